// File: rtl/imm_gen_pipe_pkg.sv
// Shared types and constants for the pipelined immediate generator.
//
// Contents:
//   INSTR_W    - width of a raw RV instruction word.
//   imm_src_e  - 3-bit immediate format select used by decode.
package imm_pkg;

  localparam int INSTR_W = 32;

  typedef enum logic [2:0] {
    IMM_I     = 3'd0,
    IMM_S     = 3'd1,
    IMM_B     = 3'd2,
    IMM_U     = 3'd3,
    IMM_J     = 3'd4,
    IMM_IU    = 3'd5,
    IMM_ZIMM  = 3'd6,
    IMM_SHAMT = 3'd7
  } imm_src_e;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Decode-to-execute immediate bus: input handshake (instr/immsrc/tag),
// output handshake (imm/tag) and a flush strobe.
//
// Modports:
//   master - decode side plus consumer ready (drives inputs, out_ready).
//   slave  - the immediate pipeline (drives in_ready and the outputs).
interface imm_gen_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
);
  import imm_pkg::*;

  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] instr;
  logic [2:0]         immsrc;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [XLEN-1:0]    out_imm;
  logic [TAG_W-1:0]   out_tag;

  modport master (
    output flush, in_valid, instr, immsrc, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_tag
  );

  modport slave (
    input  flush, in_valid, instr, immsrc, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_tag
  );

endinterface

// File: rtl/imm_gen_pipe_extend.sv
// imm_extend: purely combinational RV immediate format mux.
//
// Ports:
//   instr  in  32    raw instruction word
//   immsrc in  3     format select (imm_src_e)
//   imm    out XLEN  sign/zero-extended immediate (XLEN = 32 or 64)
module imm_extend
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [INSTR_W-1:0] instr,
  input  imm_src_e           immsrc,
  output logic [XLEN-1:0]    imm
);

  // Every format is first built as a 32-bit value; sext_s says whether
  // bit 31 is replicated into the upper word when XLEN is 64.
  logic [31:0] lo_s;
  logic        sext_s;
  logic [63:0] wide_s;
  logic        unused_s;

  // Format mux producing the low word and its extension mode.
  always_comb begin
    lo_s   = 32'h0000_0000;
    sext_s = 1'b0;
    case (immsrc)
      IMM_I: begin
        lo_s   = {{20{instr[31]}}, instr[31:20]};
        sext_s = 1'b1;
      end
      IMM_S: begin
        lo_s   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        sext_s = 1'b1;
      end
      IMM_B: begin
        lo_s   = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
        sext_s = 1'b1;
      end
      IMM_U: begin
        lo_s   = {instr[31:12], 12'h000};
        sext_s = 1'b1;
      end
      IMM_J: begin
        lo_s   = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
        sext_s = 1'b1;
      end
      IMM_IU: begin
        lo_s   = {20'h00000, instr[31:20]};
        sext_s = 1'b0;
      end
      IMM_ZIMM: begin
        lo_s   = {27'h0000000, instr[19:15]};
        sext_s = 1'b0;
      end
      IMM_SHAMT: begin
        // RV64 shift amounts carry one more bit than RV32.
        if (XLEN == 64) begin
          lo_s = {26'h0000000, instr[25:20]};
        end else begin
          lo_s = {27'h0000000, instr[24:20]};
        end
        sext_s = 1'b0;
      end
      default: begin
        lo_s   = 32'h0000_0000;
        sext_s = 1'b0;
      end
    endcase
  end

  assign wide_s = {{32{sext_s & lo_s[31]}}, lo_s};
  assign imm    = wide_s[XLEN-1:0];

  // Opcode bits never feed an immediate; upper word is dropped for RV32.
  assign unused_s = ^{instr[6:0], wide_s};

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: immediate generator with STAGES register stages, a
// valid/ready handshake with bubble collapse, flush and a sideband tag.
//
// Ports:
//   clk  in   rising-edge clock
//   rst  in   asynchronous active-high reset
//   bus  slave modport of imm_gen_pipe_if (flush, in_valid/in_ready,
//        instr, immsrc, in_tag, out_valid/out_ready, out_imm, out_tag)
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int STAGES = 1,
  parameter int TAG_W  = 8
) (
  input  logic           clk,
  input  logic           rst,
  imm_gen_pipe_if.slave  bus
);

  logic [XLEN-1:0]   ext_s;
  logic [STAGES-1:0] v_r;
  logic [XLEN-1:0]   imm_r [STAGES];
  logic [TAG_W-1:0]  tag_r [STAGES];

  logic [STAGES-1:0] ld_s;      // stage may take new contents this edge
  logic              chain_s;
  logic [STAGES-1:0] up_v_s;
  logic [XLEN-1:0]   up_imm_s [STAGES];
  logic [TAG_W-1:0]  up_tag_s [STAGES];

  imm_extend #(.XLEN(XLEN)) u_extend (
    .instr  (bus.instr),
    .immsrc (imm_src_e'(bus.immsrc)),
    .imm    (ext_s)
  );

  // Ready chain from the output back to the input: a stage can load when
  // it is empty or when the stage after it can load (last stage: out_ready).
  always_comb begin
    ld_s    = '0;
    chain_s = bus.out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      ld_s[k] = !v_r[k] || chain_s;
      chain_s = ld_s[k];
    end
  end

  // Upstream view of each stage: the extender for stage 0, else stage k-1.
  always_comb begin
    up_v_s      = '0;
    up_v_s[0]   = bus.in_valid && ld_s[0];
    up_imm_s[0] = ext_s;
    up_tag_s[0] = bus.in_tag;
    for (int k = 1; k < STAGES; k++) begin
      up_v_s[k]   = v_r[k-1];
      up_imm_s[k] = imm_r[k-1];
      up_tag_s[k] = tag_r[k-1];
    end
  end

  // Pipeline registers; flush clears every valid but leaves data stale.
  // Data is only written when a real entry moves in, so held or bubble
  // stages keep their last contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_r <= '0;
      for (int k = 0; k < STAGES; k++) begin
        imm_r[k] <= '0;
        tag_r[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (ld_s[k]) begin
          v_r[k] <= up_v_s[k] && !bus.flush;
        end else begin
          v_r[k] <= v_r[k] && !bus.flush;
        end
        if (ld_s[k] && up_v_s[k]) begin
          imm_r[k] <= up_imm_s[k];
          tag_r[k] <= up_tag_s[k];
        end
      end
    end
  end

  assign bus.in_ready  = ld_s[0];
  assign bus.out_valid = v_r[STAGES-1];
  assign bus.out_imm   = imm_r[STAGES-1];
  assign bus.out_tag   = tag_r[STAGES-1];

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Parametrised, pipelined successor to the decode-stage sign extender.
- Generates XLEN-wide immediates from a 32-bit RV instruction for 8 formats: I, S, B, U, J, unsigned-I, CSR zimm and shamt.
- Output is registered through STAGES pipeline registers with a valid/ready handshake, flush and a pass-through sideband tag.
- Sits between the instruction-decode stage and the execute stage.

Parameters:
- XLEN, 32, output width; legal values 32 or 64.
- STAGES, 1, number of register stages, 1..3.
- TAG_W, 8, width of the sideband tag carried alongside each immediate (e.g. rd/ROB id).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  drop all in-flight entries.
- in_valid  input  1  instr/immsrc/tag are valid this cycle.
- in_ready  output  1  block accepts input this cycle.
- instr  input  32  raw instruction word.
- immsrc  input  3  format select (encoding below).
- in_tag  input  TAG_W  sideband data.
- out_valid  output  1  out_imm/out_tag valid.
- out_ready  input  1  consumer accepts output.
- out_imm  output  XLEN  extended immediate.
- out_tag  output  TAG_W  tag matching out_imm.

Behaviour:
- Format encoding (s = instr[31]; sign-extension always fills to XLEN):
  - 000 I: sext(instr[31:20]).
  - 001 S: sext({instr[31:25], instr[11:7]}).
  - 010 B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - 011 U: sext({instr[31:12], 12'b0}); for XLEN=64 bits 63:32 = s.
  - 100 J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
  - 101 unsigned-I: zext(instr[31:20]).
  - 110 CSR zimm: zext(instr[19:15]).
  - 111 shamt: zext(instr[25:20]) if XLEN=64, zext(instr[24:20]) if XLEN=32.
- Extension is combinational at the input; the result is captured in stage 0.
- Stage k holds valid v[k], imm[k] and tag[k]. The last stage drives the outputs.
- Advance rules:
  - adv[last] = out_ready.
  - adv[k] = !v[k+1] | adv[k+1].
  - in_ready = !v[0] | adv[0]. This is a combinational ready chain with bubble collapse.
- On each clock edge, for every stage k with (!v[k] | adv[k]):
  - stage k loads from stage k-1, or from the input for k=0.
  - v[k] takes the upstream valid, which for stage 0 is in_valid & in_ready.
- Stages that do not advance hold data and valid unchanged. Data registers never change while held.
- Latency is STAGES cycles from accepted input to out_valid. Throughput is 1 per cycle when out_ready is held high.
- No duplication or loss: every accepted input appears exactly once on the output, in order.
- Flush: on the edge where flush=1, all v[k] clear.
  - An input presented in the same cycle is discarded, even if in_ready=1. Flush wins.
  - The output handshake in that cycle still counts if out_valid & out_ready.
  - The data registers may keep stale values.
- Reset, asynchronous:
  - all v[k] = 0, so out_valid = 0.
  - all imm/tag registers = 0, so out_imm = 0 and out_tag = 0.
  - in_ready = 1 after reset.
- Reset asserted mid-operation drops all entries immediately, without waiting for a clock edge.
- Full: all STAGES entries are valid and out_ready=0, so in_ready=0.
- Empty: in_ready=1 and out_valid=0.

Decomposition:
- Package imm_pkg holds:
  - enum imm_src_e {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_IU, IMM_ZIMM, IMM_SHAMT} (3-bit).
  - localparam INSTR_W = 32.
- Sub-module imm_extend #(XLEN): purely combinational format mux, reusable by other decode logic. imm_gen_pipe instantiates it and adds the pipeline and handshake.

Test Plan:
- XLEN=32, STAGES=1, out_ready=1; instr=0xFFF00093, immsrc=000 -> 1 cycle later out_valid=1, out_imm=0xFFFFFFFF, tag echoed.
- B and J formats: instr=0xFE000EE3, immsrc=010 -> 0xFFFFFFFC; instr=0x0010006F, immsrc=100 -> 0x00000800.
- XLEN=64: instr=0x800000B7, immsrc=011 -> 0xFFFFFFFF80000000; instr=0x000FD073, immsrc=110 -> 0x1F; instr=0x03F01013, immsrc=111 -> 0x3F.
- Backpressure, STAGES=2, out_ready=0, 3 back-to-back inputs with tags 1,2,3:
  - tags 1 and 2 are accepted, then in_ready drops.
  - Releasing out_ready yields tags 1,2,3 in order, with no duplicates.
- Flush with in_valid=1 in the same cycle, pipeline holding 2 entries -> next cycle out_valid=0 and the input is not seen at the output.
- Assert rst mid-stream between clock edges -> out_valid, out_imm and out_tag go to 0 immediately; in_ready=1.
